// File: rtl/neuron_layer_seq_pkg.sv
// Shared fixed-point types, layer-state enum and saturation helpers for neuron_layer_seq.
`ifndef FRAC_BITS
`define FRAC_BITS 8
`endif

package neuron_layer_seq_pkg;

    localparam int FRAC_BITS = `FRAC_BITS;
    localparam int FRAC_W    = 16;
    localparam int Z_W       = FRAC_BITS + 1;

    typedef logic signed [FRAC_W-1:0] frac_t;
    typedef logic [Z_W-1:0]           zero2one_t;

    localparam zero2one_t Z_ONE = zero2one_t'(1 << FRAC_BITS);

    localparam logic signed [63:0] FRAC_MAX = (64'sd1 <<< (FRAC_W - 1)) - 64'sd1;
    localparam logic signed [63:0] FRAC_MIN = -(64'sd1 <<< (FRAC_W - 1));

    typedef enum logic [1:0] {ST_IDLE, ST_FWD, ST_LEARN, ST_DONE} layer_state_e;

    function automatic zero2one_t sat_unit(input logic signed [63:0] v);
        if (v < 0) return '0;
        if (v > $signed(64'(Z_ONE))) return Z_ONE;
        return v[Z_W-1:0];
    endfunction

    function automatic frac_t sat_frac(input logic signed [63:0] v);
        if (v > FRAC_MAX) return frac_t'(FRAC_MAX);
        if (v < FRAC_MIN) return frac_t'(FRAC_MIN);
        return frac_t'(v);
    endfunction

endpackage

// File: rtl/neuron_dot_sat.sv
// Combinational N-wide multiply-accumulate; exposes the per-lane products and
// the accumulated sum scaled by FRAC_BITS and saturated to [0, 1.0].
module neuron_dot_sat
    import neuron_layer_seq_pkg::*;
#(
    parameter int N  = 16,
    parameter int DW = Z_W + 1,
    parameter int PW = FRAC_W + DW
) (
    input  frac_t     [N-1:0]         coef_i,
    input  logic      [N-1:0][DW-1:0] data_i,
    output logic      [N-1:0][PW-1:0] prod_o,
    output zero2one_t                 sat_o
);

    localparam int ACC_W = PW + $clog2(N);

    logic signed [ACC_W-1:0] acc;

    always_comb begin
        acc = '0;
        for (int j = 0; j < N; j++) begin
            prod_o[j] = PW'($signed(PW'($signed(coef_i[j]))) * $signed(PW'($signed(data_i[j]))));
            acc       = acc + ACC_W'($signed(prod_o[j]));
        end
    end

    assign sat_o = sat_unit(64'(acc >>> FRAC_BITS));

endmodule

// File: rtl/neuron_layer_seq.sv
// Time-multiplexed neuron layer: one shared dot/update datapath walks M neurons.
// Learning pass and back-propagation sums are built only with NEURON_LAYER_SEQ_LEARN_EN.
module neuron_layer_seq
    import neuron_layer_seq_pkg::*;
#(
    parameter int    N           = 16,
    parameter int    M           = 28,
    parameter int    LR_SHIFT    = 4,
    parameter frac_t WEIGHT_INIT = frac_t'(0)
) (
    input  logic                        clock,
    input  logic                        reset_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic                        learn,
    input  zero2one_t [N-1:0]           in,
    input  zero2one_t [M-1:0]           expected_out,
    output logic                        out_valid,
    input  logic                        out_ready,
    output zero2one_t [M-1:0]           out,
    output zero2one_t [N-1:0]           expected_in,
    output frac_t     [M-1:0][N-1:0]    weights
);

    localparam int KW = (M > 1) ? $clog2(M) : 1;
    localparam int DW = Z_W + 1;
    localparam int PW = FRAC_W + DW;
    localparam logic [KW-1:0] K_LAST = KW'(M - 1);

    layer_state_e               state_q, state_d;
    logic [KW-1:0]              k_q, k_d;
    zero2one_t [N-1:0]          in_q, in_d;
    zero2one_t [M-1:0]          out_q, out_d;
    zero2one_t [N-1:0]          exp_in_q, exp_in_d;

    frac_t [N-1:0]              coef;
    logic  [N-1:0][DW-1:0]      data;
    logic  [N-1:0][PW-1:0]      prod;
    zero2one_t                  dot_sat;

`ifdef NEURON_LAYER_SEQ_LEARN_EN
    localparam int AW = PW + $clog2(M) + 2;
    localparam logic signed [AW-1:0] M_S = AW'(M);

    logic                       learn_q, learn_d;
    zero2one_t [M-1:0]          expo_q, expo_d;
    frac_t [M-1:0][N-1:0]       w_q, w_d;
    logic  [N-1:0][AW-1:0]      acc_in_q, acc_in_d;
    logic signed [DW-1:0]       err;

    // Weight step: w + (err*x) >>> (FRAC_BITS+LR_SHIFT), clamped to frac_t.
    function automatic frac_t upd_w(input frac_t w, input logic signed [DW-1:0] e,
                                    input zero2one_t x);
        logic signed [2*DW-1:0] ex;
        ex = (2*DW)'(e) * $signed((2*DW)'(x));
        return sat_frac(64'(w) + 64'(ex >>> (FRAC_BITS + LR_SHIFT)));
    endfunction

    function automatic zero2one_t div_sat(input logic [AW-1:0] a);
        logic signed [AW-1:0] q;
        q = $signed(a) / M_S;
        return sat_unit(64'(q));
    endfunction

    assign err     = $signed({1'b0, expo_q[k_q]}) - $signed({1'b0, out_q[k_q]});
    assign coef    = w_q[k_q];
    assign weights = w_q;

    always_comb begin
        for (int j = 0; j < N; j++)
            data[j] = (state_q == ST_LEARN) ? err : {1'b0, in_q[j]};
    end
`else
    logic unused_ok;
    assign unused_ok = ^{learn, expected_out, prod};

    always_comb begin
        for (int j = 0; j < N; j++) begin
            coef[j] = WEIGHT_INIT;
            data[j] = {1'b0, in_q[j]};
        end
        for (int i = 0; i < M; i++)
            for (int j = 0; j < N; j++)
                weights[i][j] = WEIGHT_INIT;
    end
`endif

    neuron_dot_sat #(.N(N), .DW(DW), .PW(PW)) u_dot (
        .coef_i (coef),
        .data_i (data),
        .prod_o (prod),
        .sat_o  (dot_sat)
    );

    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        in_d      = in_q;
        out_d     = out_q;
        exp_in_d  = exp_in_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
`ifdef NEURON_LAYER_SEQ_LEARN_EN
        learn_d   = learn_q;
        expo_d    = expo_q;
        w_d       = w_q;
        acc_in_d  = acc_in_q;
`endif
        case (state_q)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    in_d    = in;
                    k_d     = '0;
                    state_d = ST_FWD;
`ifdef NEURON_LAYER_SEQ_LEARN_EN
                    learn_d = learn;
                    expo_d  = expected_out;
`endif
                end
            end
            ST_FWD: begin
                out_d[k_q] = dot_sat;
                if (k_q == K_LAST) begin
                    k_d = '0;
`ifdef NEURON_LAYER_SEQ_LEARN_EN
                    if (learn_q) begin
                        state_d = ST_LEARN;
                    end else begin
                        state_d  = ST_DONE;
                        exp_in_d = in_q;
                    end
`else
                    state_d  = ST_DONE;
                    exp_in_d = in_q;
`endif
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
`ifdef NEURON_LAYER_SEQ_LEARN_EN
            ST_LEARN: begin
                // Back-propagated sum uses the weight before this cycle's update.
                for (int j = 0; j < N; j++) begin
                    w_d[k_q][j] = upd_w(w_q[k_q][j], err, in_q[j]);
                    acc_in_d[j] = acc_in_q[j] + AW'({1'b0, in_q[j]})
                                + AW'($signed(prod[j]) >>> FRAC_BITS);
                end
                if (k_q == K_LAST) begin
                    k_d     = '0;
                    state_d = ST_DONE;
                    for (int j = 0; j < N; j++)
                        exp_in_d[j] = div_sat(acc_in_d[j]);
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
`endif
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d  = ST_IDLE;
`ifdef NEURON_LAYER_SEQ_LEARN_EN
                    acc_in_d = '0;
`endif
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            k_q     <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            in_q     <= '0;
            out_q    <= '0;
            exp_in_q <= '0;
`ifdef NEURON_LAYER_SEQ_LEARN_EN
            learn_q  <= 1'b0;
            expo_q   <= '0;
            acc_in_q <= '0;
            for (int i = 0; i < M; i++)
                for (int j = 0; j < N; j++)
                    w_q[i][j] <= WEIGHT_INIT;
`endif
        end else begin
            in_q     <= in_d;
            out_q    <= out_d;
            exp_in_q <= exp_in_d;
`ifdef NEURON_LAYER_SEQ_LEARN_EN
            learn_q  <= learn_d;
            expo_q   <= expo_d;
            acc_in_q <= acc_in_d;
            w_q      <= w_d;
`endif
        end
    end

    assign out         = out_q;
    assign expected_in = exp_in_q;

endmodule

// File: tb/tb_neuron_layer_seq.sv
// Directed bench for neuron_layer_seq (N=4, M=3, LR_SHIFT=0); four instances with
// different WEIGHT_INIT run in lockstep from shared stimulus.
module tb_neuron_layer_seq;
    import neuron_layer_seq_pkg::*;

    localparam int TN = 4;
    localparam int TM = 3;

    logic clk = 1'b0;
    logic rst_n;
    logic in_valid, learn, out_ready;
    zero2one_t [TN-1:0] vin;
    zero2one_t [TM-1:0] vexp;

    logic rdy_a, rdy_p, rdy_n, rdy_s;
    logic ov_a, ov_p, ov_n, ov_s;
    zero2one_t [TM-1:0] out_a, out_p, out_n, out_s;
    zero2one_t [TN-1:0] ei_a, ei_p, ei_n, ei_s;
    frac_t [TM-1:0][TN-1:0] w_a, w_p, w_n, w_s;

    logic unused_tb;
    assign unused_tb = ^{rdy_p, rdy_n, rdy_s, ov_p, ov_n, ov_s, ei_n, ei_s, w_s};

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    neuron_layer_seq #(.N(TN), .M(TM), .LR_SHIFT(0), .WEIGHT_INIT(16'sd0)) u_a (
        .clock(clk), .reset_n(rst_n), .in_valid(in_valid), .in_ready(rdy_a), .learn(learn),
        .in(vin), .expected_out(vexp), .out_valid(ov_a), .out_ready(out_ready),
        .out(out_a), .expected_in(ei_a), .weights(w_a));
    neuron_layer_seq #(.N(TN), .M(TM), .LR_SHIFT(0), .WEIGHT_INIT(16'sd64)) u_p (
        .clock(clk), .reset_n(rst_n), .in_valid(in_valid), .in_ready(rdy_p), .learn(learn),
        .in(vin), .expected_out(vexp), .out_valid(ov_p), .out_ready(out_ready),
        .out(out_p), .expected_in(ei_p), .weights(w_p));
    neuron_layer_seq #(.N(TN), .M(TM), .LR_SHIFT(0), .WEIGHT_INIT(-16'sd64)) u_n (
        .clock(clk), .reset_n(rst_n), .in_valid(in_valid), .in_ready(rdy_n), .learn(learn),
        .in(vin), .expected_out(vexp), .out_valid(ov_n), .out_ready(out_ready),
        .out(out_n), .expected_in(ei_n), .weights(w_n));
    neuron_layer_seq #(.N(TN), .M(TM), .LR_SHIFT(0), .WEIGHT_INIT(16'sd32767)) u_s (
        .clock(clk), .reset_n(rst_n), .in_valid(in_valid), .in_ready(rdy_s), .learn(learn),
        .in(vin), .expected_out(vexp), .out_valid(ov_s), .out_ready(out_ready),
        .out(out_s), .expected_in(ei_s), .weights(w_s));

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic send(input zero2one_t [TN-1:0] v, input zero2one_t [TM-1:0] e,
                        input logic l);
        @(negedge clk);
        vin      = v;
        vexp     = e;
        learn    = l;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    // lat counts cycles after the accept edge: t+1 is the first FWD cycle.
    task automatic wait_out(output int lat);
        lat = 0;
        forever begin
            @(negedge clk);
            lat++;
            if (lat == 1) check("busy_in_ready", 64'(rdy_a), 64'(0));
            if (ov_a) break;
            if (lat > 40) begin
                check("tmo_out_valid", 64'(ov_a), 64'(1));
                break;
            end
        end
    endtask

    task automatic back_to_idle();
        @(negedge clk);
        check("idle_in_ready", 64'(rdy_a), 64'(1));
        check("idle_out_valid", 64'(ov_a), 64'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not reach summary");
        $fatal(1);
    end

    initial begin
        int lat;
        zero2one_t [TN-1:0] v_all, v_mix, v_one;
        zero2one_t [TM-1:0] e_half, e_zero;
        v_all  = {4{9'd256}};
        v_mix  = {9'd0, 9'd64, 9'd128, 9'd256};
        v_one  = {9'd0, 9'd0, 9'd0, 9'd256};
        e_half = {3{9'd128}};
        e_zero = '0;

        rst_n = 1'b0; in_valid = 1'b0; learn = 1'b0; out_ready = 1'b1;
        vin = '0; vexp = '0;
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready", 64'(rdy_a), 64'(1));
        check("rst_out_valid", 64'(ov_a), 64'(0));
        check("rst_out", 64'(out_p), 64'(0));
        check("rst_expected_in", 64'(ei_p), 64'(0));
        check("rst_w_p_row0", 64'(w_p[0]), {4{16'h0040}});
        check("rst_w_n_row2", 64'(w_n[2]), {4{16'hFFC0}});
        check("rst_w_a_row1", 64'(w_a[1]), 64'(0));

        // All-ones input: 4*64*256 >> 8 = 256.
        send(v_all, e_zero, 1'b0);
        wait_out(lat);
        check("inf_latency", 64'(lat), 64'(4));
        check("inf_out_w64", 64'(out_p), 64'({3{9'd256}}));
        check("inf_out_wneg", 64'(out_n), 64'(0));
        check("inf_out_wmax", 64'(out_s), 64'({3{9'd256}}));
        check("inf_expected_in", 64'(ei_p), 64'(v_all));
        back_to_idle();

        // Sum of inputs 448: 64*448 >> 8 = 112.
        send(v_mix, e_zero, 1'b0);
        wait_out(lat);
        check("mix_latency", 64'(lat), 64'(4));
        check("mix_out_w64", 64'(out_p), 64'({3{9'd112}}));
        check("mix_out_wneg", 64'(out_n), 64'(0));
        check("mix_out_wmax", 64'(out_s), 64'({3{9'd256}}));
        check("mix_expected_in", 64'(ei_p), 64'(v_mix));
        back_to_idle();

        // Backpressure: hold DONE five cycles while a new vector is offered.
        out_ready = 1'b0;
        send(v_mix, e_zero, 1'b0);
        wait_out(lat);
        check("bp_latency", 64'(lat), 64'(4));
        vin = v_one;
        in_valid = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check("bp_out_valid", 64'(ov_a), 64'(1));
            check("bp_in_ready", 64'(rdy_a), 64'(0));
            check("bp_out_stable", 64'(out_p), 64'({3{9'd112}}));
            check("bp_ei_stable", 64'(ei_p), 64'(v_mix));
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        back_to_idle();

        // Asynchronous reset in the middle of FWD.
        send(v_all, e_zero, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", 64'(ov_a), 64'(0));
        check("mid_rst_in_ready", 64'(rdy_a), 64'(1));
        check("mid_rst_out", 64'(out_p), 64'(0));
        check("mid_rst_w_p_row1", 64'(w_p[1]), {4{16'h0040}});
        @(negedge clk) rst_n = 1'b1;
        send(v_all, e_zero, 1'b0);
        wait_out(lat);
        check("post_rst_latency", 64'(lat), 64'(4));
        check("post_rst_out", 64'(out_p), 64'({3{9'd256}}));
        back_to_idle();

        send(v_one, e_half, 1'b1);
        wait_out(lat);
`ifdef NEURON_LAYER_SEQ_LEARN_EN
        // err=128 per neuron: w[k][0] gains 128*256>>8; acc_in[0]=3*256 -> 256.
        check("learn_latency", 64'(lat), 64'(7));
        check("learn_out", 64'(out_a), 64'(0));
        check("learn_expected_in", 64'(ei_a), 64'(v_one));
        for (int k = 0; k < TM; k++)
            check("learn_w_row", 64'(w_a[k]), 64'h0000_0000_0000_0080);
        back_to_idle();
        send(v_one, e_half, 1'b0);
        wait_out(lat);
        check("relearn_latency", 64'(lat), 64'(4));
        check("relearn_out", 64'(out_a), 64'({3{9'd128}}));
        back_to_idle();
        // err=-128: weights return to 0; acc_in[0]=3*(256-64) -> 192.
        send(v_one, e_zero, 1'b1);
        wait_out(lat);
        check("unlearn_latency", 64'(lat), 64'(7));
        check("unlearn_out", 64'(out_a), 64'({3{9'd128}}));
        check("unlearn_expected_in", 64'(ei_a), 64'({9'd0, 9'd0, 9'd0, 9'd192}));
        for (int k = 0; k < TM; k++)
            check("unlearn_w_row", 64'(w_a[k]), 64'(0));
        back_to_idle();
`else
        check("nolearn_latency", 64'(lat), 64'(4));
        check("nolearn_out", 64'(out_a), 64'(0));
        check("nolearn_expected_in", 64'(ei_a), 64'(v_one));
        for (int k = 0; k < TM; k++)
            check("nolearn_w_a_row", 64'(w_a[k]), 64'(0));
        check("nolearn_w_p_row", 64'(w_p[2]), {4{16'h0040}});
        back_to_idle();
        send(v_one, e_half, 1'b1);
        wait_out(lat);
        check("nolearn2_latency", 64'(lat), 64'(4));
        check("nolearn2_out_w64", 64'(out_p), 64'({3{9'd64}}));
        back_to_idle();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
